agu_queue: RTL and testbench
============================

AGU_QUEUE -- requirements
Module: agu_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register operand width; legal values are 32 and 64.
REQ-002 Parameter ADDR_WIDTH, default 32, generated address width; it SHALL be no greater than DATA_WIDTH.
REQ-003 Parameter IMM_WIDTH, default 12, signed offset width.
REQ-004 Parameter DEPTH, default 4, result queue entries; it SHALL be a power of two and at least 2.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous queue clear.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  request accepted when in_valid is high.
REQ-010 base  input  DATA_WIDTH  base register value.
REQ-011 offset  input  IMM_WIDTH  signed immediate.
REQ-012 funct3  input  3  access size/sign, RISC-V load/store encoding.
REQ-013 is_store  input  1  1 = store, 0 = load.
REQ-014 out_valid  output  1  queue head valid.
REQ-015 out_ready  input  1  consumer takes the head.
REQ-016 out_addr  output  ADDR_WIDTH  effective address.
REQ-017 out_be  output  DATA_WIDTH/8  byte enables.
REQ-018 out_funct3, out_store  output  3, 1  funct3 and is_store carried with the request.
REQ-019 out_misalign  output  1  misaligned or illegal access flag.
REQ-020 out_count  output  log2(DEPTH)+1  queue occupancy.

Function
REQ-021 Effective address SHALL be (base[ADDR_WIDTH-1:0] + sign-extended offset) mod 2^ADDR_WIDTH; wrap-around is silent.
REQ-022 Access size SHALL be funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double.
REQ-023 Misalign SHALL be set for half with addr[0]=1, for word with addr[1:0]!=0, and for double with addr[2:0]!=0.
REQ-024 Double SHALL also be flagged misaligned when DATA_WIDTH=32; funct3[2]=1 with is_store=1 SHALL be flagged as well.
REQ-025 out_be SHALL be (1, 3, F, FF for size) shifted left by addr[log2(DATA_WIDTH/8)-1:0], truncated to DATA_WIDTH/8 bits, and SHALL be all-zero whenever misalign is set.
REQ-026 Address, be, misalign, funct3 and store SHALL be computed from the request and written into the queue tail in the accept cycle.
REQ-027 Latency: out_valid rises 1 cycle after acceptance into an empty queue; there is no combinational in-to-out path.
REQ-028 Acceptance occurs when in_valid & in_ready & !flush.
REQ-029 in_ready SHALL be (out_count < DEPTH), with no same-cycle pop bypass when full.
REQ-030 A pop occurs when out_valid & out_ready; out_valid SHALL be (out_count != 0).
REQ-031 Simultaneous push and pop SHALL leave out_count unchanged and preserve FIFO order.
REQ-032 Pop on empty and push on full SHALL have no effect.
REQ-033 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-034 flush SHALL empty the queue next edge: out_count=0, pointers reset, a concurrent push dropped, a concurrent pop ignored.
REQ-035 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-036 On reset assertion, out_count=0, out_valid=0 and pointers=0 immediately, independent of clk.
REQ-037 in_ready SHALL be 1 while reset is low and the queue is empty.
REQ-038 Entries in flight at reset assertion SHALL be discarded; queue storage contents need not be cleared.
REQ-039 The first push is accepted on the first rising edge with reset low.

Verification
REQ-040 LW: base=0x1000, offset=0xFFC (-4), funct3=010 -> next cycle out_addr=0x0FFC, be=F, misalign=0.
REQ-041 SH: base=0x2001, offset=0, funct3=001, is_store=1 -> misalign=1, be=0; base=0x2002 -> be=0xC, misalign=0.
REQ-042 Wrap: base=0xFFFFFFFF, offset=1, funct3=000 -> out_addr=0x00000000, be=1.
REQ-043 Backpressure: out_ready=0, push 5 requests with DEPTH=4 -> in_ready=0 after 4 pushes, out_count=4; then out_ready=1 -> the 4 entries drain in order.
REQ-044 Concurrency: with 2 entries queued, push and pop in the same cycle -> out_count stays 2; flush asserted with in_valid=1 -> out_count=0 next cycle, out_valid=0.
REQ-045 Reset mid-operation: assert reset between clock edges with 3 entries queued -> out_valid=0 and out_count=0 before the next edge.

Source files
------------

// File: rtl/agu_queue_if.sv
// Request/result bundle between a load-store issue stage and the address-generation queue.
// The master drives requests and consumes results; the slave is the AGU queue.
interface agu_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int IMM_WIDTH  = 12,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   base;
    logic [IMM_WIDTH-1:0]    offset;
    logic [2:0]              funct3;
    logic                    is_store;

    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_addr;
    logic [DATA_WIDTH/8-1:0] out_be;
    logic [2:0]              out_funct3;
    logic                    out_store;
    logic                    out_misalign;
    logic [CNT_W-1:0]        out_count;

    modport master (
        output in_valid, base, offset, funct3, is_store, out_ready,
        input  in_ready, out_valid, out_addr, out_be, out_funct3, out_store,
               out_misalign, out_count
    );

    modport slave (
        input  in_valid, base, offset, funct3, is_store, out_ready,
        output in_ready, out_valid, out_addr, out_be, out_funct3, out_store,
               out_misalign, out_count
    );
endinterface

// File: rtl/agu_queue.sv
// Address-generation unit: computes effective address, byte enables and misalignment
// for RISC-V loads/stores and buffers the results in a DEPTH-entry FIFO.
module agu_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int IMM_WIDTH  = 12,
    parameter int DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    agu_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);

    logic [ADDR_WIDTH-1:0] off_ext_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [BE_W-1:0]       mask_s;
    logic [BE_W-1:0]       be_s;
    logic                  size_mis_s;
    logic                  mis_s;
    logic                  push_s;
    logic                  pop_s;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [BE_W-1:0]       be_mem_q   [DEPTH];
    logic [2:0]            f3_mem_q   [DEPTH];
    logic                  st_mem_q   [DEPTH];
    logic                  mis_mem_q  [DEPTH];

    assign off_ext_s = ADDR_WIDTH'(signed'(bus.offset));
    assign addr_s    = bus.base[ADDR_WIDTH-1:0] + off_ext_s;

    // Size decode: natural-alignment check and the unshifted byte mask per access size.
    always_comb begin
        mask_s     = '0;
        size_mis_s = 1'b0;
        case (bus.funct3[1:0])
            2'b00: begin
                mask_s     = BE_W'(8'h01);
                size_mis_s = 1'b0;
            end
            2'b01: begin
                mask_s     = BE_W'(8'h03);
                size_mis_s = addr_s[0];
            end
            2'b10: begin
                mask_s     = BE_W'(8'h0F);
                size_mis_s = (addr_s[1:0] != 2'b00);
            end
            2'b11: begin
                mask_s     = BE_W'(8'hFF);
                size_mis_s = (addr_s[2:0] != 3'b000) || (DATA_WIDTH == 32);
            end
            default: begin
                mask_s     = '0;
                size_mis_s = 1'b1;
            end
        endcase
    end

    // Unsigned stores do not exist, so funct3[2] with a store is an illegal encoding.
    assign mis_s = size_mis_s | (bus.funct3[2] & bus.is_store);

    // Byte enables are suppressed entirely for any flagged access.
    always_comb begin
        be_s = '0;
        if (mis_s) begin
            be_s = '0;
        end else begin
            be_s = mask_s << addr_s[OFF_W-1:0];
        end
    end

    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);

    assign push_s = bus.in_valid & bus.in_ready & ~flush;
    assign pop_s  = bus.out_valid & bus.out_ready & ~flush;

    // Pointer and occupancy next-state; flush overrides any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control state, cleared asynchronously so outputs drop without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_q[wr_ptr_q] <= addr_s;
            be_mem_q[wr_ptr_q]   <= be_s;
            f3_mem_q[wr_ptr_q]   <= bus.funct3;
            st_mem_q[wr_ptr_q]   <= bus.is_store;
            mis_mem_q[wr_ptr_q]  <= mis_s;
        end
    end

    assign bus.out_addr     = addr_mem_q[rd_ptr_q];
    assign bus.out_be       = be_mem_q[rd_ptr_q];
    assign bus.out_funct3   = f3_mem_q[rd_ptr_q];
    assign bus.out_store    = st_mem_q[rd_ptr_q];
    assign bus.out_misalign = mis_mem_q[rd_ptr_q];
    assign bus.out_count    = count_q;

endmodule

// File: tb/tb_agu_queue.sv
// Directed and randomized checks of agu_queue against a queue-based reference model.
module tb_agu_queue;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int IW    = 12;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [2:0]  f3;
        logic        st;
        logic        mis;
    } ent_t;

    logic clk;
    logic reset;
    logic flush;
    int   n_cmp;
    int   n_fail;
    ent_t mq[$];

    agu_queue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMM_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    agu_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMM_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the address, size in bytes, modulo alignment.
    function automatic ent_t model_req(input logic [31:0] b, input logic [11:0] o,
                                       input logic [2:0] f3, input logic st);
        ent_t        e;
        longint      s;
        int          nbytes;
        logic [15:0] w;
        s      = longint'(b) + longint'($signed(o));
        e.addr = s[31:0];
        nbytes = 1 << f3[1:0];
        e.mis  = ((e.addr % nbytes) != 0) || (nbytes == 8) || (f3[2] && st);
        w      = ((16'd1 << nbytes) - 16'd1) << (e.addr % 4);
        e.be   = e.mis ? 4'h0 : w[3:0];
        e.f3   = f3;
        e.st   = st;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] b, input logic [11:0] o,
                         input logic [2:0] f3, input logic st);
        bus.in_valid = v;
        bus.base     = b;
        bus.offset   = o;
        bus.funct3   = f3;
        bus.is_store = st;
    endtask

    // One clock: check outputs against the model at negedge, then advance both.
    task automatic cycle();
        bit   push;
        bit   pop;
        ent_t e;
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("out_count", 64'(bus.out_count), 64'(mq.size()));
        if (mq.size() != 0) begin
            chk("head_addr", 64'(bus.out_addr), 64'(mq[0].addr));
            chk("head_be", 64'(bus.out_be), 64'(mq[0].be));
            chk("head_mis", 64'(bus.out_misalign), 64'(mq[0].mis));
            chk("head_f3", 64'(bus.out_funct3), 64'(mq[0].f3));
            chk("head_st", 64'(bus.out_store), 64'(mq[0].st));
        end
        push = bus.in_valid && (mq.size() < DEPTH) && !flush;
        pop  = (mq.size() != 0) && bus.out_ready && !flush;
        e    = model_req(bus.base, bus.offset, bus.funct3, bus.is_store);
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 12'h0, 3'b000, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count", 64'(bus.out_count), 64'd0);
        reset = 1'b0;

        // LW with negative offset
        drive(1'b1, 32'h0000_1000, 12'hFFC, 3'b010, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 12'h0, 3'b000, 1'b0);
        chk("lw_addr", 64'(bus.out_addr), 64'h0FFC);
        chk("lw_be", 64'(bus.out_be), 64'hF);
        chk("lw_mis", 64'(bus.out_misalign), 64'd0);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;

        // SH misaligned then aligned
        drive(1'b1, 32'h0000_2001, 12'h000, 3'b001, 1'b1);
        cycle();
        drive(1'b1, 32'h0000_2002, 12'h000, 3'b001, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 12'h0, 3'b000, 1'b0);
        chk("sh_mis1", 64'(bus.out_misalign), 64'd1);
        chk("sh_be1", 64'(bus.out_be), 64'h0);
        bus.out_ready = 1'b1;
        cycle();
        chk("sh_mis2", 64'(bus.out_misalign), 64'd0);
        chk("sh_be2", 64'(bus.out_be), 64'hC);
        cycle();
        bus.out_ready = 1'b0;

        // address wrap-around
        drive(1'b1, 32'hFFFF_FFFF, 12'h001, 3'b000, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 12'h0, 3'b000, 1'b0);
        chk("wrap_addr", 64'(bus.out_addr), 64'h0);
        chk("wrap_be", 64'(bus.out_be), 64'h1);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;

        // backpressure: five pushes into a four-deep queue
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h3000 + 32'(i * 4), 12'h0, 3'b010, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 12'h0, 3'b000, 1'b0);
        chk("bp_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_count", 64'(bus.out_count), 64'd4);
        chk("bp_head", 64'(bus.out_addr), 64'h3000);
        bus.out_ready = 1'b1;
        repeat (5) cycle();
        chk("bp_drained", 64'(bus.out_count), 64'd0);
        bus.out_ready = 1'b0;

        // simultaneous push/pop, then flush with a concurrent push
        drive(1'b1, 32'h4000, 12'h0, 3'b000, 1'b0);
        repeat (2) cycle();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h4100, 12'h0, 3'b000, 1'b0);
        cycle();
        chk("pp_count", 64'(bus.out_count), 64'd2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 32'h0, 12'h0, 3'b000, 1'b0);
        bus.out_ready = 1'b0;
        chk("fl_count", 64'(bus.out_count), 64'd0);
        chk("fl_valid", 64'(bus.out_valid), 64'd0);

        // asynchronous reset with three entries in flight
        drive(1'b1, 32'h5000, 12'h0, 3'b001, 1'b0);
        repeat (3) cycle();
        drive(1'b0, 32'h0, 12'h0, 3'b000, 1'b0);
        chk("pre_rst_count", 64'(bus.out_count), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_count", 64'(bus.out_count), 64'd0);
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h6000, 12'h008, 3'b011, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 12'h0, 3'b000, 1'b0);
        chk("post_rst_count", 64'(bus.out_count), 64'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] b;
            b = $urandom;
            if ($urandom_range(0, 1) == 0) b = b & 32'hFFFF_FFF8;
            drive(1'($urandom_range(0, 1)), b, 12'($urandom),
                  3'($urandom), 1'($urandom_range(0, 1)));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
